// File: rtl/digit_tx_pkg.sv
// Shared encodings and constants for the ASCII digit serial transmitter.
package digit_tx_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam int         FRAME_BITS = 10;
   // Start and stop bits bracket the data bits of each character.
   localparam int         DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/digit_tx_baud.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and strobes bit_end on the last one.
module digit_tx_baud #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic bit_end
);

   localparam int            BW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

   logic [BW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear)
         cnt <= '0;
      else if (run)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

   assign bit_end = run && (cnt == LAST);

endmodule

// File: rtl/digit_uart_tx.sv
// Watches the digit-bank change flag and sends a snapshot of all digits, MS first,
// followed by CR, as back-to-back 8N1 characters on tx_out.
module digit_uart_tx
   import digit_tx_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [8*NUM_DIGITS-1:0] digit_in,
   input  logic                    flag_in,
   input  logic                    tx_enable,
   output logic                    tx_out,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    pending
);

   localparam int            CW        = $clog2(NUM_DIGITS + 1);
   localparam logic [CW-1:0] LAST_CHAR = CW'(NUM_DIGITS);
   localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);

   tx_state_e               state, state_n;
   logic                    last_flag;
   logic [8*NUM_DIGITS-1:0] snapshot;
   logic [7:0]              shift, shift_n;
   logic [2:0]              bit_cnt, bit_cnt_n;
   logic [CW-1:0]           char_idx, char_idx_n, nxt_idx;
   logic [7:0]              nxt_char;
   logic                    tx_n, done_n;
   logic                    change, start, bit_end;

   assign change = (flag_in != last_flag);
   assign start  = (state == IDLE) && (change || pending) && tx_enable;
   assign busy   = (state != IDLE);

   digit_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk     (clk),
      .reset   (reset),
      .clear   (start),
      .run     (busy),
      .bit_end (bit_end)
   );

   // Character following the current one: a snapshot digit, or CR after the last digit.
   always_comb begin
      nxt_idx  = char_idx + 1'b1;
      nxt_char = ASCII_CR;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (nxt_idx == CW'(i))
            nxt_char = snapshot[8*(NUM_DIGITS-1-i) +: 8];
   end

   always_comb begin
      state_n    = state;
      shift_n    = shift;
      bit_cnt_n  = bit_cnt;
      char_idx_n = char_idx;
      tx_n       = tx_out;
      done_n     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               // Snapshot is loaded on this same edge, so take the first char from digit_in.
               state_n    = START;
               shift_n    = digit_in[8*NUM_DIGITS-1 -: 8];
               char_idx_n = '0;
               bit_cnt_n  = '0;
               tx_n       = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_n   = DATA;
               bit_cnt_n = '0;
               tx_n      = shift[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt == LAST_DATA) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_cnt_n = bit_cnt + 1'b1;
                  shift_n   = shift >> 1;
                  tx_n      = shift[1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (char_idx < LAST_CHAR) begin
                  state_n    = START;
                  char_idx_n = nxt_idx;
                  shift_n    = nxt_char;
                  tx_n       = 1'b0;
               end else begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_flag  <= 1'b1;
         pending    <= 1'b0;
         snapshot   <= '0;
         shift      <= '0;
         bit_cnt    <= '0;
         char_idx   <= '0;
         tx_out     <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         last_flag  <= flag_in;
         shift      <= shift_n;
         bit_cnt    <= bit_cnt_n;
         char_idx   <= char_idx_n;
         tx_out     <= tx_n;
         frame_done <= done_n;
         if (start)
            snapshot <= digit_in;
         // Changes that cannot start a frame right now coalesce into one pending frame.
         if (start)
            pending <= 1'b0;
         else if (change && (busy || !tx_enable))
            pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_digit_uart_tx.sv
// Directed bench for digit_uart_tx: a 4-digit/4-clk instance and a 1-digit/2-clk instance.
module tb_digit_uart_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] digit;
   logic        flag, en;
   logic        tx, busy, done, pend;
   logic [7:0]  digit1;
   logic        flag1, en1;
   logic        tx1, busy1, done1, pend1;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int cpb  = 4;
   int last_start;
   int f0, bad;
   bit sel = 1'b0;

   logic tx_mon, busy_mon, done_mon;
   assign tx_mon   = sel ? tx1   : tx;
   assign busy_mon = sel ? busy1 : busy;
   assign done_mon = sel ? done1 : done;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   digit_uart_tx #(.NUM_DIGITS(4), .CLKS_PER_BIT(4)) dut (
      .clk(clk), .reset(reset), .digit_in(digit), .flag_in(flag), .tx_enable(en),
      .tx_out(tx), .busy(busy), .frame_done(done), .pending(pend)
   );

   digit_uart_tx #(.NUM_DIGITS(1), .CLKS_PER_BIT(2)) dut1 (
      .clk(clk), .reset(reset), .digit_in(digit1), .flag_in(flag1), .tx_enable(en1),
      .tx_out(tx1), .busy(busy1), .frame_done(done1), .pending(pend1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Finds the next start bit (bounded), then samples mid-bit data and stop.
   task automatic rx_byte(input string tag, input logic [7:0] exp);
      logic [7:0] b;
      logic       stp;
      int         n = 0;
      while (tx_mon !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (tx_mon !== 1'b0) begin
         check({tag, "_start"}, {31'd0, tx_mon}, 32'd0);
         return;
      end
      last_start = cyc;
      repeat (cpb + cpb/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         b[i] = tx_mon;
         if (i < 7) repeat (cpb) @(negedge clk);
      end
      repeat (cpb) @(negedge clk);
      stp = tx_mon;
      check(tag, {23'd0, stp, b}, {23'd0, 1'b1, exp});
   endtask

   task automatic wait_done(input string tag, input int start_cyc, input int len);
      int n = 0;
      while (done_mon !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_len"}, cyc - start_cyc, len);
      check({tag, "_busy"}, {31'd0, busy_mon}, 32'd0);
   endtask

   task automatic idle_watch(input int ncyc, output int nbad);
      nbad = 0;
      repeat (ncyc) begin
         @(negedge clk);
         if (tx_mon !== 1'b1 || busy_mon !== 1'b0 || done_mon !== 1'b0) nbad++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; flag = 1'b1; en = 1'b1; digit = 32'h0;
      flag1 = 1'b1; en1 = 1'b1; digit1 = 8'h0;
      repeat (3) @(negedge clk);
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_pend", {31'd0, pend}, 32'd0);
      reset = 1'b0;

      // 1: flag held at its reset value -> nothing happens
      idle_watch(200, bad);
      check("t1_quiet", bad, 0);

      // 2: single frame "1234" CR
      digit = 32'h31323334;
      flag = 1'b0;
      @(negedge clk);
      check("t2_txfall", {31'd0, tx}, 32'd0);
      check("t2_busy", {31'd0, busy}, 32'd1);
      rx_byte("t2_b0", 8'h31); f0 = last_start;
      rx_byte("t2_b1", 8'h32);
      rx_byte("t2_b2", 8'h33);
      rx_byte("t2_b3", 8'h34);
      rx_byte("t2_b4", 8'h0D);
      wait_done("t2", f0, 200);

      // 3: digits and two flag toggles mid-frame -> one follow-up frame
      flag = 1'b1;
      rx_byte("t3_b0", 8'h31); f0 = last_start;
      digit = 32'h35363738;
      flag = 1'b0;
      @(negedge clk);
      flag = 1'b1;
      @(negedge clk);
      check("t3_pend", {31'd0, pend}, 32'd1);
      rx_byte("t3_b1", 8'h32);
      rx_byte("t3_b2", 8'h33);
      rx_byte("t3_b3", 8'h34);
      rx_byte("t3_b4", 8'h0D);
      wait_done("t3", f0, 200);
      check("t3_pend_done", {31'd0, pend}, 32'd1);
      check("t3_tx_done", {31'd0, tx}, 32'd1);
      @(negedge clk);
      check("t3_restart_tx", {31'd0, tx}, 32'd0);
      check("t3_restart_pend", {31'd0, pend}, 32'd0);
      rx_byte("t3_c0", 8'h35); f0 = last_start;
      rx_byte("t3_c1", 8'h36);
      rx_byte("t3_c2", 8'h37);
      rx_byte("t3_c3", 8'h38);
      rx_byte("t3_c4", 8'h0D);
      wait_done("t3b", f0, 200);
      idle_watch(20, bad);
      check("t3_no_third", bad, 0);

      // 4: tx_enable low holds the change pending
      en = 1'b0;
      flag = 1'b0;
      @(negedge clk);
      check("t4_pend", {31'd0, pend}, 32'd1);
      idle_watch(100, bad);
      check("t4_held", bad, 0);
      en = 1'b1;
      @(negedge clk);
      check("t4_start_tx", {31'd0, tx}, 32'd0);
      check("t4_start_pend", {31'd0, pend}, 32'd0);
      rx_byte("t4_b0", 8'h35); f0 = last_start;
      wait_done("t4", f0, 200);

      // 5: reset during char 2, data bit 3
      flag = 1'b1;
      rx_byte("t5_b0", 8'h35); f0 = last_start;
      while (cyc < f0 + 97) @(negedge clk);
      flag = 1'b0;
      @(negedge clk);
      check("t5_pend_pre", {31'd0, pend}, 32'd1);
      check("t5_busy_pre", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      flag = 1'b1;
      @(negedge clk);
      check("t5_rst_tx", {31'd0, tx}, 32'd1);
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      check("t5_rst_pend", {31'd0, pend}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idle_watch(100, bad);
      check("t5_quiet", bad, 0);

      // 6: one digit, 2 clocks per bit
      sel = 1'b1;
      cpb = 2;
      digit1 = 8'h39;
      flag1 = 1'b0;
      @(negedge clk);
      check("t6_txfall", {31'd0, tx1}, 32'd0);
      rx_byte("t6_b0", 8'h39); f0 = last_start;
      rx_byte("t6_b1", 8'h0D);
      wait_done("t6", f0, 40);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
